iomem_interconnect: RTL and testbench

- Parametrised successor to the hand-written iomem decode in the SoC top level.
- Routes one picosoc iomem master to N_SLAVES peripherals, each selected by its address page (addr[31:24]).
- Adds a registered response path, a bus-timeout watchdog and an error/default responder for unmapped or hung accesses.
- Sits between picosoc iomem_* and peripherals such as gpio_led, audio and timer_counter.

---
 rtl/iomem_interconnect.sv | 146 ++++++++++++++
 tb/tb_iomem_interconnect.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_interconnect.sv
// rtl/iomem_interconnect.sv - picosoc iomem page decoder with timeout watchdog and error responder
// Optional first-error address capture: IOMEM_INTERCONNECT_ERR_ADDR_EN
module iomem_interconnect #(
    parameter int                    N_SLAVES      = 4,
    parameter logic [8*N_SLAVES-1:0] PAGE_MAP      = {8'h06, 8'h05, 8'h04, 8'h03},
    parameter int                    TIMEOUT       = 255,
    parameter int                    TO_W          = 8,
    parameter logic [31:0]           DEFAULT_RDATA = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [3:0]               m_wstrb,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    output logic [31:0]              m_rdata,
    output logic [N_SLAVES-1:0]      s_valid,
    input  logic [N_SLAVES-1:0]      s_ready,
    input  logic [32*N_SLAVES-1:0]   s_rdata,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic                     err_irq,
    output logic                     err_sticky,
    input  logic                     err_clr,
    output logic [31:0]              err_addr
);
    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state, state_nx;
    logic [SEL_W-1:0] sel, sel_nx, hit_idx;
    logic             hit;
    logic [TO_W-1:0]  cnt;
    logic             err_flag, err_nx;
    logic             turn;
    logic [31:0]      rdata_nx;
    logic [31:0]      sel_rdata;
    logic             sel_rdy;
    logic             set_err;

    assign s_wstrb   = m_wstrb;
    assign s_addr    = m_addr;
    assign s_wdata   = m_wdata;
    assign sel_rdata = s_rdata[32*sel +: 32];
    assign sel_rdy   = s_ready[sel];

    assign m_ready = (state == RESP);
    assign err_irq = m_ready && err_flag;
    assign s_valid = (state == WAIT) ? (N_SLAVES'(1) << sel) : '0;
    assign set_err = err_irq;

    // Scan high to low so the lowest matching index is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (m_addr[31:24] == PAGE_MAP[8*i +: 8]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        err_nx   = err_flag;
        rdata_nx = m_rdata;
        case (state)
            IDLE: begin
                // turn blocks re-decoding of a request still held from the last completion
                if (m_valid && !turn) begin
                    if (hit) begin
                        sel_nx   = hit_idx;
                        err_nx   = 1'b0;
                        state_nx = WAIT;
                    end else begin
                        rdata_nx = DEFAULT_RDATA;
                        err_nx   = 1'b1;
                        state_nx = RESP;
                    end
                end
            end
            WAIT: begin
                if (!m_valid) begin
                    state_nx = IDLE;
                end else if (sel_rdy) begin
                    rdata_nx = sel_rdata;
                    err_nx   = 1'b0;
                    state_nx = RESP;
                end else if (cnt == TO_W'(TIMEOUT)) begin
                    rdata_nx = DEFAULT_RDATA;
                    err_nx   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            sel        <= '0;
            cnt        <= '0;
            err_flag   <= 1'b0;
            turn       <= 1'b0;
            m_rdata    <= '0;
            err_sticky <= 1'b0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            err_flag <= err_nx;
            m_rdata  <= rdata_nx;
            turn     <= (state == RESP);
            cnt      <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (set_err)
                err_sticky <= 1'b1;
            else if (err_clr)
                err_sticky <= 1'b0;
        end
    end

`ifdef IOMEM_INTERCONNECT_ERR_ADDR_EN
    logic [31:0] err_addr_q;

    // m_addr is still held by the master during RESP, so it is captured there
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            err_addr_q <= '0;
        else if (set_err && (!err_sticky || err_clr))
            err_addr_q <= m_addr;
        else if (err_clr)
            err_addr_q <= '0;
    end

    assign err_addr = err_addr_q;
`else
    assign err_addr = 32'h0;
`endif

endmodule

// File: tb/tb_iomem_interconnect.sv
// tb/tb_iomem_interconnect.sv - directed self-checking bench for iomem_interconnect
module tb_iomem_interconnect;
    logic         clk = 1'b0;
    logic         resetn;
    logic         m_valid;
    logic         m_ready;
    logic [3:0]   m_wstrb;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic [3:0]   s_wstrb;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic         err_irq;
    logic         err_sticky;
    logic         err_clr;
    logic [31:0]  err_addr;

    int vectors = 0;
    int miscompares = 0;

    iomem_interconnect dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata),
        .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .err_irq(err_irq), .err_sticky(err_sticky), .err_clr(err_clr), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle first so the post-completion turnaround cycle never swallows a request
    task automatic begin_req(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
        tick();
        m_addr  = a;
        m_wstrb = ws;
        m_wdata = wd;
        m_valid = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) tick();
        vectors++; if (m_ready !== 1'b0) begin miscompares++; $display("FAIL reset_m_ready: got %b expected 0", m_ready); end
        vectors++; if (s_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_s_valid: got %b expected 0000", s_valid); end
        vectors++; if (m_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_m_rdata: got %h expected 00000000", m_rdata); end
        vectors++; if (err_sticky !== 1'b0 || err_irq !== 1'b0) begin miscompares++; $display("FAIL reset_err: got sticky=%b irq=%b expected 0 0", err_sticky, err_irq); end
        vectors++; if (err_addr !== 32'h0) begin miscompares++; $display("FAIL reset_err_addr: got %h expected 00000000", err_addr); end
        resetn = 1'b1;
    endtask

    task automatic test_read_mapped();
        int nsv = 0;
        begin_req(32'h0400_0010, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (s_valid === 4'b0010 && m_ready === 1'b0) nsv++;
            if (k == 2) s_ready = 4'b0010;
        end
        vectors++; if (nsv !== 3) begin miscompares++; $display("FAIL read_s_valid_cycles: got %0d expected 3", nsv); end
        tick();
        s_ready = 4'b0000;
        vectors++; if (m_ready !== 1'b1) begin miscompares++; $display("FAIL read_m_ready: got %b expected 1", m_ready); end
        vectors++; if (m_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL read_m_rdata: got %h expected 12345678", m_rdata); end
        vectors++; if (s_valid !== 4'b0000 || err_irq !== 1'b0) begin miscompares++; $display("FAIL read_resp_side: got s_valid=%b irq=%b expected 0000 0", s_valid, err_irq); end
        m_valid = 1'b0;
        tick();
        vectors++; if (m_ready !== 1'b0 || err_sticky !== 1'b0) begin miscompares++; $display("FAIL read_after: got m_ready=%b sticky=%b expected 0 0", m_ready, err_sticky); end
        vectors++; if (m_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL read_rdata_hold: got %h expected 12345678", m_rdata); end
    endtask

    task automatic test_write_turnaround();
        begin_req(32'h0300_0000, 4'hF, 32'h0000_00A5);
        #1;
        vectors++; if (s_wdata !== 32'hA5 || s_wstrb !== 4'hF || s_addr !== 32'h0300_0000) begin miscompares++; $display("FAIL write_broadcast: got wdata=%h wstrb=%h addr=%h expected a5 f 03000000", s_wdata, s_wstrb, s_addr); end
        tick();
        vectors++; if (s_valid !== 4'b0001) begin miscompares++; $display("FAIL write_s_valid: got %b expected 0001", s_valid); end
        s_ready = 4'b0001;
        tick();
        s_ready = 4'b0000;
        vectors++; if (m_ready !== 1'b1 || m_rdata !== 32'h0000_1111) begin miscompares++; $display("FAIL write_resp: got m_ready=%b rdata=%h expected 1 00001111", m_ready, m_rdata); end
        tick();
        vectors++; if (m_ready !== 1'b0) begin miscompares++; $display("FAIL write_single_pulse: got %b expected 0", m_ready); end
        tick();
        vectors++; if (s_valid !== 4'b0000 || m_ready !== 1'b0) begin miscompares++; $display("FAIL turnaround_no_redecode: got s_valid=%b m_ready=%b expected 0000 0", s_valid, m_ready); end
        m_valid = 1'b0;
        tick();
        vectors++; if (s_valid !== 4'b0000) begin miscompares++; $display("FAIL turnaround_idle: got %b expected 0000", s_valid); end
    endtask

    task automatic test_unmapped();
        begin_req(32'h0700_0000, 4'h0, 32'h0);
        tick();
        vectors++; if (m_ready !== 1'b1 || err_irq !== 1'b1) begin miscompares++; $display("FAIL unmapped_resp: got m_ready=%b irq=%b expected 1 1", m_ready, err_irq); end
        vectors++; if (m_rdata !== 32'hDEAD_BEEF || s_valid !== 4'b0000) begin miscompares++; $display("FAIL unmapped_data: got rdata=%h s_valid=%b expected deadbeef 0000", m_rdata, s_valid); end
        m_valid = 1'b0;
        tick();
        vectors++; if (err_sticky !== 1'b1 || err_irq !== 1'b0) begin miscompares++; $display("FAIL unmapped_sticky: got sticky=%b irq=%b expected 1 0", err_sticky, err_irq); end
`ifdef IOMEM_INTERCONNECT_ERR_ADDR_EN
        vectors++; if (err_addr !== 32'h0700_0000) begin miscompares++; $display("FAIL unmapped_err_addr: got %h expected 07000000", err_addr); end
`else
        vectors++; if (err_addr !== 32'h0) begin miscompares++; $display("FAIL unmapped_err_addr: got %h expected 00000000", err_addr); end
`endif
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++; if (err_sticky !== 1'b0 || err_addr !== 32'h0) begin miscompares++; $display("FAIL err_clear: got sticky=%b addr=%h expected 0 00000000", err_sticky, err_addr); end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        logic [3:0] last_sv = 4'b0000;
        begin_req(32'h0600_0000, 4'h0, 32'h0);
        for (int k = 1; k <= 300; k++) begin
            tick();
            cyc = k;
            if (m_ready === 1'b1) break;
            last_sv = s_valid;
        end
        vectors++; if (cyc !== 257 || m_ready !== 1'b1) begin miscompares++; $display("FAIL timeout_latency: got cycle %0d m_ready=%b expected 257 1", cyc, m_ready); end
        vectors++; if (m_rdata !== 32'hDEAD_BEEF || err_irq !== 1'b1) begin miscompares++; $display("FAIL timeout_resp: got rdata=%h irq=%b expected deadbeef 1", m_rdata, err_irq); end
        vectors++; if (last_sv !== 4'b1000 || s_valid !== 4'b0000) begin miscompares++; $display("FAIL timeout_s_valid: got before=%b at=%b expected 1000 0000", last_sv, s_valid); end
        m_valid = 1'b0;
        tick();
        vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b expected 1", err_sticky); end
        begin_req(32'h0500_0004, 4'h0, 32'h0);
        tick();
        vectors++; if (s_valid !== 4'b0100) begin miscompares++; $display("FAIL post_timeout_s_valid: got %b expected 0100", s_valid); end
        s_ready = 4'b0100;
        tick();
        s_ready = 4'b0000;
        vectors++; if (m_ready !== 1'b1 || m_rdata !== 32'hCAFE_0002 || err_irq !== 1'b0) begin miscompares++; $display("FAIL post_timeout_read: got m_ready=%b rdata=%h irq=%b expected 1 cafe0002 0", m_ready, m_rdata, err_irq); end
        m_valid = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_ignore_and_race();
        int early = 0;
        begin_req(32'h0300_0000, 4'h0, 32'h0);
        tick();
        vectors++; if (s_valid !== 4'b0001) begin miscompares++; $display("FAIL race_s_valid: got %b expected 0001", s_valid); end
        s_ready = 4'b0100;
        for (int k = 2; k <= 256; k++) begin
            tick();
            if (m_ready !== 1'b0) early++;
        end
        vectors++; if (early !== 0) begin miscompares++; $display("FAIL unselected_ready_ignored: got %0d early completions expected 0", early); end
        s_ready = 4'b0101;
        tick();
        s_ready = 4'b0000;
        vectors++; if (m_ready !== 1'b1 || err_irq !== 1'b0 || m_rdata !== 32'h0000_1111) begin miscompares++; $display("FAIL ready_wins_timeout: got m_ready=%b irq=%b rdata=%h expected 1 0 00001111", m_ready, err_irq, m_rdata); end
        m_valid = 1'b0;
        tick();
        vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL race_no_error: got sticky=%b expected 0", err_sticky); end
    endtask

    task automatic test_async_reset_and_clr();
        begin_req(32'h0900_0000, 4'h0, 32'h0);
        tick();
        m_valid = 1'b0;
        tick();
        begin_req(32'h0400_0000, 4'h0, 32'h0);
        tick();
        vectors++; if (s_valid !== 4'b0010 || err_sticky !== 1'b1) begin miscompares++; $display("FAIL prereset_state: got s_valid=%b sticky=%b expected 0010 1", s_valid, err_sticky); end
        #2;
        resetn = 1'b0;
        #1;
        vectors++; if (s_valid !== 4'b0000 || m_ready !== 1'b0 || err_sticky !== 1'b0) begin miscompares++; $display("FAIL async_reset: got s_valid=%b m_ready=%b sticky=%b expected 0000 0 0", s_valid, m_ready, err_sticky); end
        m_valid = 1'b0;
        tick();
        resetn = 1'b1;
        begin_req(32'h0900_0000, 4'h0, 32'h0);
        tick();
        vectors++; if (m_ready !== 1'b1 || err_irq !== 1'b1) begin miscompares++; $display("FAIL restart_from_idle: got m_ready=%b irq=%b expected 1 1", m_ready, err_irq); end
        m_valid = 1'b0;
        tick();
        begin_req(32'h0A00_0000, 4'h0, 32'h0);
        tick();
        err_clr = 1'b1;
        m_valid = 1'b0;
        tick();
        err_clr = 1'b0;
        vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL set_wins_over_clr: got %b expected 1", err_sticky); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL final_clear: got %b expected 0", err_sticky); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_valid = 1'b0;
        m_wstrb = 4'h0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        s_ready = 4'b0000;
        s_rdata = {32'h4444_4444, 32'hCAFE_0002, 32'h1234_5678, 32'h0000_1111};
        err_clr = 1'b0;
        test_reset();
        test_read_mapped();
        test_write_turnaround();
        test_unmapped();
        test_timeout();
        test_ignore_and_race();
        test_async_reset_and_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
